// File: rtl/boa_csr_hpm_if.sv
// boa_csr_bus: zero-latency CSR overlay port.
// Slave sees we/addr/wdata and answers exists/rdonly/priv/rdata.
interface boa_csr_bus;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        exists;
  logic        rdonly;
  logic [1:0]  priv;
  logic [31:0] rdata;

  modport CSR (
    input  we, addr, wdata,
    output exists, rdonly, priv, rdata
  );

  modport OVL (
    output we, addr, wdata,
    input  exists, rdonly, priv, rdata
  );
endinterface

// File: rtl/boa_csr_hpm.sv
// boa_csr_hpm: mcycle/minstret/mhpmcounterN CSR slave with
// event selectors, inhibit, counter-enable and wrap pulses.
module boa_csr_hpm #(
  parameter int hpm_count   = 4,
  parameter int ctr_width   = 40,
  parameter int event_count = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  boa_csr_bus.CSR                csr,
  input  logic                   retire,
  input  logic [event_count-1:0] ev,
  output logic [hpm_count+2:0]   ovf
);
  localparam int N  = hpm_count + 3;
  localparam int W  = ctr_width;
  localparam int SW = $clog2(event_count + 1);
  localparam logic [31:0] IMPL =
    32'((64'd1 << N) - 64'd1) & ~32'd2;

  logic [W-1:0]  ctr_q [N];
  logic [W-1:0]  ctr_d [N];
  logic [SW-1:0] sel_q [N];
  logic [SW-1:0] sel_d [N];
  logic [31:0]   inh_q, inh_d;
  logic [31:0]   en_q, en_d;
  logic [N-1:0]  ovf_q, ovf_d;
  logic [N-1:0]  inc;
  logic [N-1:0]  wr_lo, wr_hi, wr_ev;
  logic          wr_inh, wr_en;
  logic          exists, rdonly;
  logic [1:0]    priv;
  logic [31:0]   rdata;

  // Address decode, read mux and write strobes.
  always_comb begin
    exists = 1'b0;
    rdonly = 1'b0;
    priv   = 2'b00;
    rdata  = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    wr_ev  = '0;
    wr_inh = 1'b0;
    wr_en  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i != 1) begin
        if (csr.addr == 12'(32'hB00 + i)) begin
          exists   = 1'b1;
          priv     = 2'b11;
          rdata    = ctr_q[i][31:0];
          wr_lo[i] = csr.we;
        end
        if (csr.addr == 12'(32'hB80 + i)) begin
          exists   = 1'b1;
          priv     = 2'b11;
          rdata    = 32'(ctr_q[i] >> 32);
          wr_hi[i] = csr.we;
        end
        if (csr.addr == 12'(32'hC00 + i)) begin
          exists = 1'b1;
          rdonly = 1'b1;
          priv   = en_q[i] ? 2'b00 : 2'b11;
          rdata  = ctr_q[i][31:0];
        end
        if (csr.addr == 12'(32'hC80 + i)) begin
          exists = 1'b1;
          rdonly = 1'b1;
          priv   = en_q[i] ? 2'b00 : 2'b11;
          rdata  = 32'(ctr_q[i] >> 32);
        end
        if (i >= 3 && csr.addr == 12'(32'h320 + i)) begin
          exists   = 1'b1;
          priv     = 2'b11;
          rdata    = 32'(sel_q[i]);
          wr_ev[i] = csr.we;
        end
      end
    end
    if (csr.addr == 12'h320) begin
      exists = 1'b1;
      priv   = 2'b11;
      rdata  = inh_q & IMPL;
      wr_inh = csr.we;
    end
    if (csr.addr == 12'h306) begin
      exists = 1'b1;
      priv   = 2'b11;
      rdata  = en_q & IMPL;
      wr_en  = csr.we;
    end
  end

  // Per-counter increment request, gated by the current inhibit.
  always_comb begin
    inc = '0;
    for (int i = 0; i < N; i++) begin
      unique case (1'b1)
        (i == 0): inc[i] = 1'b1;
        (i == 2): inc[i] = retire;
        (i >= 3): begin
          for (int e = 0; e < event_count; e++) begin
            if (int'(sel_q[i]) == e + 1) inc[i] = ev[e];
          end
        end
        default: inc[i] = 1'b0;
      endcase
      inc[i] = inc[i] & ~inh_q[i];
    end
  end

  // Next state: a write beats a same-cycle increment.
  always_comb begin
    inh_d = wr_inh ? (csr.wdata & IMPL) : inh_q;
    en_d  = wr_en  ? (csr.wdata & IMPL) : en_q;
    ovf_d = '0;
    for (int i = 0; i < N; i++) begin
      ctr_d[i] = ctr_q[i];
      sel_d[i] = wr_ev[i] ? csr.wdata[SW-1:0] : sel_q[i];
      if (wr_lo[i] || wr_hi[i]) begin
        if (wr_lo[i]) ctr_d[i][31:0] = csr.wdata;
        if (wr_hi[i]) ctr_d[i][W-1:32] = csr.wdata[W-33:0];
      end else if (inc[i]) begin
        ctr_d[i] = ctr_q[i] + W'(1);
        ovf_d[i] = &ctr_q[i];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= '0;
        sel_q[i] <= '0;
      end
      inh_q <= '0;
      en_q  <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= ctr_d[i];
        sel_q[i] <= sel_d[i];
      end
      inh_q <= inh_d;
      en_q  <= en_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf        = ovf_q;
  assign csr.exists = exists;
  assign csr.rdonly = rdonly;
  assign csr.priv   = priv;
  assign csr.rdata  = rdata;
endmodule

// File: tb/tb_boa_csr_hpm.sv
// tb_boa_csr_hpm: table vectors, directed corner sequences and
// random traffic checked against a behavioural counter model.
module tb_boa_csr_hpm;
  localparam int HPM = 4;
  localparam int W   = 40;
  localparam int EVN = 8;
  localparam int N   = HPM + 3;
  localparam longint unsigned MOD = 64'd1 << W;

  logic           clk = 1'b0;
  logic           rst;
  logic           retire;
  logic [EVN-1:0] ev;
  logic [N-1:0]   ovf;

  boa_csr_bus bus();

  boa_csr_hpm #(
    .hpm_count(HPM),
    .ctr_width(W),
    .event_count(EVN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .csr(bus),
    .retire(retire),
    .ev(ev),
    .ovf(ovf)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  longint unsigned m_ctr [N];
  int              m_sel [N];
  int              m_inh;
  int              m_en;
  logic [N-1:0]    m_ovf;

  typedef struct {
    int          addr;
    bit          ex;
    bit          ro;
    logic [1:0]  pv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string n, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_ctr[i] = 0;
      m_sel[i] = 0;
    end
    m_inh = 0;
    m_en  = 0;
    m_ovf = '0;
  endtask

  function automatic void m_read(input int a, output bit ex,
                                 output bit ro, output int pv,
                                 output longint unsigned rd);
    int off;
    int grp;
    ex = 0; ro = 0; pv = 0; rd = 0;
    off = a & 'h7F;
    grp = a >> 7;
    if (a == 'h320) begin
      ex = 1; pv = 3; rd = 64'(m_inh);
    end else if (a == 'h306) begin
      ex = 1; pv = 3; rd = 64'(m_en);
    end else if (a >= 'h323 && a < 'h320 + N) begin
      ex = 1; pv = 3; rd = 64'(m_sel[a - 'h320]);
    end else if (grp >= 'h16 && grp <= 'h19 && off < N && off != 1) begin
      ex = 1;
      ro = (grp >= 'h18);
      pv = (ro && ((m_en >> off) & 1) == 1) ? 0 : 3;
      rd = (grp[0]) ? (m_ctr[off] >> 32) : (m_ctr[off] & 64'hFFFFFFFF);
    end
  endfunction

  task automatic m_edge();
    int a;
    bit hit;
    logic [N-1:0] nov;
    a = int'(bus.addr);
    nov = '0;
    if (rst) begin
      m_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (i == 1) continue;
      if (bus.we && a == 'hB00 + i) begin
        m_ctr[i] = (m_ctr[i] & ~64'hFFFFFFFF) | 64'(bus.wdata);
      end else if (bus.we && a == 'hB80 + i) begin
        m_ctr[i] = (m_ctr[i] & 64'hFFFFFFFF) |
                   ((64'(bus.wdata) % (MOD >> 32)) << 32);
      end else if (((m_inh >> i) & 1) == 0) begin
        if (i == 0) hit = 1;
        else if (i == 2) hit = retire;
        else hit = (m_sel[i] >= 1 && m_sel[i] <= EVN &&
                    ((ev >> (m_sel[i] - 1)) & 1) != 0);
        if (hit) begin
          m_ctr[i] = m_ctr[i] + 1;
          if (m_ctr[i] == MOD) begin
            m_ctr[i] = 0;
            nov[i] = 1'b1;
          end
        end
      end
    end
    if (bus.we) begin
      if (a == 'h320) m_inh = int'(bus.wdata) & 'h7D;
      if (a == 'h306) m_en  = int'(bus.wdata) & 'h7D;
      if (a >= 'h323 && a < 'h320 + N)
        m_sel[a - 'h320] = int'(bus.wdata & 32'hF);
    end
    m_ovf = nov;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = 12'(a);
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
  endtask

  task automatic probe(input int a);
    bit ex, ro;
    int pv;
    longint unsigned rd, exp, act;
    bus.addr = 12'(a);
    #1;
    m_read(a, ex, ro, pv, rd);
    exp = (64'(ex) << 35) | (64'(ro) << 34) | (64'(pv) << 32) | rd;
    act = {28'd0, bus.exists, bus.rdonly, bus.priv, bus.rdata};
    chk($sformatf("read %03h", a), act, exp);
  endtask

  task automatic rdc(input string n, input int a,
                     input longint unsigned e);
    bus.addr = 12'(a);
    #1;
    chk(n, 64'(bus.rdata), e);
  endtask

  int alist [] = '{'hB00, 'hB80, 'hB02, 'hB82, 'hB03, 'hB04, 'hB05,
                   'hB06, 'hB83, 'hB86, 'h323, 'h324, 'h325, 'h326,
                   'h320, 'h306, 'hC00, 'hC83, 'hB01, 'h7C0, 'hB07};

  initial begin
    tbl[0]  = '{'hB00, 1, 0, 3, 10};
    tbl[1]  = '{'hB80, 1, 0, 3, 0};
    tbl[2]  = '{'hC00, 1, 1, 3, 10};
    tbl[3]  = '{'hC80, 1, 1, 3, 0};
    tbl[4]  = '{'hB02, 1, 0, 3, 0};
    tbl[5]  = '{'hC02, 1, 1, 3, 0};
    tbl[6]  = '{'hB03, 1, 0, 3, 0};
    tbl[7]  = '{'hB06, 1, 0, 3, 0};
    tbl[8]  = '{'hB07, 0, 0, 0, 0};
    tbl[9]  = '{'hB01, 0, 0, 0, 0};
    tbl[10] = '{'hB1F, 0, 0, 0, 0};
    tbl[11] = '{'h7C0, 0, 0, 0, 0};
    tbl[12] = '{'hC81, 0, 0, 0, 0};
    tbl[13] = '{'h320, 1, 0, 3, 0};
    tbl[14] = '{'h306, 1, 0, 3, 0};
    tbl[15] = '{'h323, 1, 0, 3, 0};
    tbl[16] = '{'h326, 1, 0, 3, 0};
    tbl[17] = '{'h327, 0, 0, 0, 0};
    tbl[18] = '{'h321, 0, 0, 0, 0};

    rst       = 1'b1;
    retire    = 1'b0;
    ev        = '0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset ovf", 64'(ovf), 0);
    rdc("reset b00", 'hB00, 0);

    repeat (10) step();
    foreach (tbl[k]) begin
      bus.addr = 12'(tbl[k].addr);
      #1;
      chk($sformatf("tbl %03h", tbl[k].addr),
          {28'd0, bus.exists, bus.rdonly, bus.priv, bus.rdata},
          {28'd0, tbl[k].ex, tbl[k].ro, tbl[k].pv, tbl[k].rd});
    end

    wr('h323, 2);
    ev = 8'b0000_0011;
    repeat (5) step();
    ev = 8'b0000_0001;
    repeat (3) step();
    rdc("hpm3 count", 'hB03, 5);
    wr('h323, 9);
    ev = 8'hFF;
    repeat (4) step();
    rdc("hpm3 halted", 'hB03, 5);
    rdc("sel readback", 'h323, 9);
    ev = '0;

    wr('hB80, 'hFF);
    wr('hB00, 'hFFFF_FFFE);
    step();
    chk("pre-wrap ovf0", 64'(ovf[0]), 0);
    rdc("pre-wrap lo", 'hB00, 'hFFFF_FFFF);
    step();
    chk("wrap ovf0", 64'(ovf[0]), 1);
    rdc("wrap lo", 'hB00, 0);
    rdc("wrap hi", 'hB80, 0);
    step();
    chk("post-wrap ovf0", 64'(ovf[0]), 0);
    rdc("post-wrap lo", 'hB00, 1);

    wr('h320, 4);
    repeat (3) begin
      retire = 1'b1; step();
      retire = 1'b0; step();
    end
    rdc("instret inhibited", 'hB02, 0);
    wr('h320, 0);
    repeat (3) begin
      retire = 1'b1; step();
      retire = 1'b0; step();
    end
    rdc("instret +3", 'hB02, 3);
    retire = 1'b1;
    wr('hB02, 7);
    retire = 1'b0;
    rdc("write beats inc", 'hB02, 7);
    retire = 1'b1;
    wr('h320, 'hFFFF_FFFF);
    rdc("inhibit late", 'hB02, 8);
    step();
    rdc("inhibit held", 'hB02, 8);
    rdc("inhibit mask", 'h320, 'h7D);
    retire = 1'b0;
    wr('h320, 0);

    bus.addr = 12'hC00;
    #1;
    chk("c00 priv m", 64'(bus.priv), 3);
    probe('hC00);
    wr('h306, 1);
    bus.addr = 12'hC00;
    #1;
    chk("c00 priv u", 64'(bus.priv), 0);
    wr('hC00, 'h1234_5678);
    probe('hC00);
    probe('hB00);
    probe('hC82);
    probe('h306);

    repeat (400) begin
      int a;
      logic [31:0] d;
      retire = 1'($urandom);
      ev     = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        a = alist[$urandom_range(0, alist.size() - 1)];
        if ($urandom_range(0, 9) == 0) a = int'($urandom & 'hFFF);
        d = $urandom;
        if ((a & 'hF80) == 'hB80 && $urandom_range(0, 1) == 1)
          d = 32'hFF;
        if ((a & 'hF80) == 'hB00 && $urandom_range(0, 1) == 1)
          d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        if (a == 'h320) d = $urandom & $urandom;
        bus.we    = 1'b1;
        bus.addr  = 12'(a);
        bus.wdata = d;
      end
      step();
      bus.we = 1'b0;
      probe(alist[$urandom_range(0, alist.size() - 1)]);
      probe(alist[$urandom_range(0, alist.size() - 1)]);
    end

    ev        = '1;
    retire    = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 12'hB00;
    bus.wdata = 32'h5;
    step();
    #20;
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst ovf", 64'(ovf), 0);
    probe('hB00);
    probe('hB02);
    probe('hB03);
    probe('h323);
    probe('h320);
    probe('h306);
    bus.addr = 12'hB00;
    step();
    bus.we = 1'b0;
    rst    = 1'b0;
    step();
    rdc("resume cycle", 'hB00, 1);
    rdc("resume instret", 'hB02, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/boa_csr_hpm.md
Name: boa_csr_hpm

Overview:
Parametrised counter/performance-monitor CSR slave for the Boa³² core. It implements mcycle, minstret and a configurable set of mhpmcounterN, each with its event selector. It also implements mcountinhibit and mcounteren, and read-only user shadows of all counters. It attaches as one port of the CSR overlay through a boa_csr_bus CSR modport, zero latency, and adds free-running, event-driven counter state with overflow reporting.

Parameters:
hpm_count, 4, number of mhpmcounterN implemented, N = 3..hpm_count+2; legal 0..29.
ctr_width, 40, implemented bits per counter; legal 33..64; bits above read 0.
event_count, 8, number of event inputs; selector value k (1..event_count) selects ev[k-1].

Ports:
clk  input  1  core clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
csr  interface  boa_csr_bus.CSR  CSR access bus: we, addr, wdata in; exists, rdonly, priv, rdata out.
retire  input  1  one instruction retired this cycle.
ev  input  event_count  per-cycle event strobes, level-sampled each clk.
ovf  output  hpm_count+3  one-cycle pulse per counter index 0..hpm_count+2 on wrap; index 1 is always 0.

Behaviour:
- Address map, with i = counter index (0 = cycle, 2 = instret, 3..hpm_count+2 = hpm):
  - M counter low 0xB00+i, high 0xB80+i.
  - User shadow low 0xC00+i, high 0xC80+i.
  - mhpmevent 0x320+i for i >= 3.
  - mcountinhibit 0x320.
  - mcounteren 0x306.
- Index 1 (time) is not implemented here; exists=0 for 0xB01/0xB81/0xC01/0xC81.
- exists=1 only for the mapped addresses above with implemented i. Otherwise exists=0, rdonly=0, priv=0, rdata=0.
- rdonly=1 for 0xCxx shadows, 0 elsewhere.
- priv=2'b11 for all M addresses.
- priv for a shadow at index i: 2'b00 if mcounteren[i]=1, else 2'b11.
- rdata is combinational from current state, 0 latency:
  - low = counter[31:0]; high = counter[ctr_width-1:32], zero-extended.
  - mhpmevent reads its stored selector.
  - mcountinhibit and mcounteren read only implemented bits (0, 2, 3..hpm_count+2); all other bits read 0.
- Writes occur on a rising clk with csr.we=1 at a writable M address. Writes to shadows or unmapped addresses are ignored.
  - Low write replaces bits 31:0. High write replaces bits ctr_width-1:32 with wdata truncated.
  - mhpmevent stores wdata[$clog2(event_count+1)-1:0]; upper bits are ignored and read back 0.
  - mcountinhibit and mcounteren store implemented bits only.
- Increment per clk, when the counter is not inhibited:
  - cycle +1 every clk.
  - instret +1 when retire=1.
  - hpm i +1 when its selector k is in 1..event_count and ev[k-1]=1.
  - Selector 0 or out-of-range: no count.
- Inhibit: mcountinhibit[i]=1 freezes counter i. A write to counter i still takes effect.
- Write versus increment in the same cycle on the same counter: the write wins.
  - The unwritten half keeps its pre-increment value.
  - No increment is applied that cycle; no ovf.
- A write to mcountinhibit takes effect from the next cycle; the current cycle uses the old inhibit value.
- Wrap: counter all-ones plus increment becomes 0. The matching ovf[i] pulses high for exactly the following cycle, registered.
- Reset (async, any time including mid-write): all counters 0, selectors 0, mcountinhibit 0, mcounteren 0, ovf 0. Counting resumes the first clk after rst deasserts.
- Width arithmetic: counters are ctr_width bits, unsigned, modulo 2^ctr_width.

Test Plan:
- Reset then 10 idle clks, read 0xB00 -> 10. Read 0xB80 -> 0; ovf stays 0.
- Write mhpmevent3 (0x323)=2, drive ev[1]=1 for 5 clks and ev[0]=1 throughout, read 0xB03 -> 5. Write selector 9 (out of range) -> count halts.
- ctr_width=40: write 0xB80=0xFF and 0xB00=0xFFFFFFFE, then 2 clks -> counter 0. ovf[0] pulses once on the cycle after the wrap; read 0xB80 -> 0.
- Set mcountinhibit=0x4, pulse retire 3 times -> minstret unchanged. Clear inhibit, pulse retire 3 times -> +3. Write 0xB02=7 while retire=1 -> reads 7.
- mcounteren=0: 0xC00 reports exists=1, rdonly=1, priv=3. Set mcounteren bit0 -> priv=0. Write 0xC00 -> ignored, rdata equals 0xB00.
- Probe 0xB01, 0xB1F (hpm_count=4) and 0x7C0 -> exists=0 and rdata=0. Assert rst mid-count -> all reads 0 immediately.
